wb_stream_reader_ctrl: RTL and testbench
========================================

WB_STREAM_READER_CTRL -- requirements
Module: wb_stream_reader_ctrl

Interface
REQ-001 SHALL have parameter WB_AW, default 32: Wishbone address width.
REQ-002 SHALL have parameter WB_DW, default 32: Wishbone data width; only 32 is supported.
REQ-003 SHALL have parameter FIFO_AW, default 0: source FIFO address width; a value of 0 is an elaboration error.
REQ-004 SHALL have parameter MAX_BURST_LEN, default 0: largest supported burst_size; it must be set to at least 2.
REQ-005 SHALL have ports: wb_clk_i in 1, system clock; wb_rst_ni in 1, asynchronous active-low reset.
REQ-006 SHALL have Wishbone master ports: wbm_adr_o out WB_AW; wbm_dat_o out WB_DW; wbm_sel_o out WB_DW/8; wbm_we_o out 1; wbm_cyc_o out 1; wbm_stb_o out 1; wbm_cti_o out 3; wbm_bte_o out 2; wbm_dat_i in WB_DW (unused); wbm_ack_i in 1; wbm_err_i in 1.
REQ-007 SHALL have FIFO ports: fifo_d in WB_DW, head word (first-word-fall-through); fifo_rd out 1, pop strobe; fifo_cnt in FIFO_AW+1, words held.
REQ-008 SHALL have config ports: busy out 1; enable in 1, start pulse; tx_cnt out WB_DW, words written in the current buffer pass; start_adr in WB_AW; buf_size in WB_AW, in bytes; burst_size in WB_AW, in words; err out 1, sticky bus-error flag.

Function
REQ-009 SHALL hold constant outputs: wbm_we_o=1, wbm_sel_o=all ones, wbm_bte_o=00, wbm_dat_o=fifo_d, fifo_rd=wbm_ack_i AND active.
REQ-010 SHALL implement FSM states S_IDLE and S_ACTIVE; wbm_cyc_o = wbm_stb_o = (state==S_ACTIVE).
REQ-011 In S_IDLE, enable=1 SHALL set busy=1 on the next edge; enable while busy=1 SHALL be ignored.
REQ-012 In S_IDLE with busy=1 and fifo_cnt >= burst_size, the FSM SHALL enter S_ACTIVE on the next edge; otherwise it SHALL remain in S_IDLE.
REQ-013 wbm_adr_o SHALL equal start_adr + 4*tx_cnt, truncated to WB_AW bits.
REQ-014 wbm_cti_o SHALL be 000 in S_IDLE, 111 on the last beat (burst_cnt==burst_size-1), and 010 on all other beats.
REQ-015 The burst counter burst_cnt SHALL clear in S_IDLE and increment on each ack in S_ACTIVE.
REQ-016 On each ack, tx_cnt SHALL increment, or wrap to 0 when tx_cnt == buf_size/4-1.
REQ-017 An ack on the last beat SHALL return the FSM to S_IDLE; if that beat was also the last address, busy SHALL clear on the same edge.
REQ-018 wbm_err_i in S_ACTIVE SHALL force S_IDLE and set err=1 and busy=0; it SHALL NOT pop the FIFO or advance tx_cnt.
REQ-019 err SHALL clear on the next enable pulse.
REQ-020 If ack and err are asserted in the same cycle, err SHALL take priority.
REQ-021 Software SHALL guarantee buf_size is a multiple of 4*burst_size and 1 <= burst_size <= min(MAX_BURST_LEN, 2**FIFO_AW); behaviour outside these limits is undefined.
REQ-022 Latency from enable to first wbm_stb_o SHALL be 2 cycles when the FIFO already holds a full burst.

Reset
REQ-023 When wb_rst_ni=0, the block SHALL immediately set state=S_IDLE, busy=0, err=0, tx_cnt=0, burst_cnt=0, and irq=0 (if present), regardless of the clock.
REQ-024 A reset asserted mid-burst SHALL drop wbm_cyc_o, wbm_stb_o and fifo_rd to 0 immediately; the partial burst is abandoned.

Configuration
REQ-025 Macro WB_STREAM_READER_IRQ_EN defined SHALL add output irq (1 bit), pulsed high for exactly one cycle on the edge where busy falls due to buffer completion or error.
REQ-026 Without WB_STREAM_READER_IRQ_EN, the irq port SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-027 start_adr=0x1000, buf_size=32, burst_size=4, fifo_cnt=8, enable pulse, zero-wait ack -> two bursts at 0x1000-0x100C and 0x1010-0x101C; cti 010,010,010,111 per burst; 8 fifo_rd pulses; busy falls after word 8; tx_cnt=0.
REQ-028 fifo_cnt=3, burst_size=4, busy=1 -> stays in S_IDLE, cyc=0; after fifo_cnt becomes 4 -> cyc rises on the next edge.
REQ-029 wbm_err_i asserted on beat 2 of a burst -> cyc drops next edge; err=1, busy=0; tx_cnt=1; exactly 1 fifo_rd pulse.
REQ-030 wb_rst_ni pulled low mid-burst between clock edges -> cyc, stb, fifo_rd and busy all 0 immediately; tx_cnt=0.
REQ-031 Ack stalled (wait states) for 3 cycles on beat 1 -> address, cti and fifo_d held stable; no fifo_rd pulse until ack.
REQ-032 With WB_STREAM_READER_IRQ_EN defined, running REQ-027 -> a single one-cycle irq pulse coincides with the busy falling edge.

Source files
------------

// File: rtl/wb_stream_reader_ctrl_if.sv
// Wishbone master bus bundle for the stream reader.
// Carries the write-burst signals between the master and its slave.
interface wb_stream_reader_ctrl_if #(
    parameter int WB_AW = 32,
    parameter int WB_DW = 32
);
    logic [WB_AW-1:0]   wbm_adr_o;
    logic [WB_DW-1:0]   wbm_dat_o;
    logic [WB_DW/8-1:0] wbm_sel_o;
    logic               wbm_we_o;
    logic               wbm_cyc_o;
    logic               wbm_stb_o;
    logic [2:0]         wbm_cti_o;
    logic [1:0]         wbm_bte_o;
    logic [WB_DW-1:0]   wbm_dat_i;
    logic               wbm_ack_i;
    logic               wbm_err_i;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o,
        output wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i
    );
endinterface

// File: rtl/wb_stream_reader_ctrl.sv
// Drains a FIFO into a circular memory buffer using Wishbone write bursts.
// Optional WB_STREAM_READER_IRQ_EN adds a one-cycle irq on completion/error.
module wb_stream_reader_ctrl #(
    parameter int WB_AW         = 32,
    parameter int WB_DW         = 32,
    parameter int FIFO_AW       = 0,
    parameter int MAX_BURST_LEN = 0
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    wb_stream_reader_ctrl_if.master wbm,
    input  logic [WB_DW-1:0]   fifo_d,
    output logic               fifo_rd,
    input  logic [FIFO_AW:0]   fifo_cnt,
    output logic               busy,
    input  logic               enable,
    output logic [WB_DW-1:0]   tx_cnt,
    input  logic [WB_AW-1:0]   start_adr,
    input  logic [WB_AW-1:0]   buf_size,
    input  logic [WB_AW-1:0]   burst_size,
`ifdef WB_STREAM_READER_IRQ_EN
    output logic               irq,
`endif
    output logic               err
);

    if (FIFO_AW == 0) begin : g_bad_fifo_aw
        $error("FIFO_AW must be nonzero");
    end
    if (MAX_BURST_LEN < 2) begin : g_bad_burst
        $error("MAX_BURST_LEN must be at least 2");
    end
    if (WB_DW != 32) begin : g_bad_dw
        $error("only WB_DW=32 is supported");
    end

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    state_t           state;
    logic [WB_AW-1:0] burst_cnt;
    logic [WB_AW-1:0] tx_w;
    logic             active;
    logic             last_beat;
    logic             last_adr;
    logic             fifo_ok;
    logic             unused;

    assign tx_w      = WB_AW'(tx_cnt);
    assign active    = (state == S_ACTIVE);
    assign last_beat = (burst_cnt == burst_size - WB_AW'(1));
    assign last_adr  = (tx_w == (buf_size >> 2) - WB_AW'(1));
    assign fifo_ok   = (WB_AW'(fifo_cnt) >= burst_size);
    assign unused    = ^{wbm.wbm_dat_i, buf_size[1:0]};

    assign wbm.wbm_adr_o = start_adr + (tx_w << 2);
    assign wbm.wbm_dat_o = fifo_d;
    assign wbm.wbm_sel_o = '1;
    assign wbm.wbm_we_o  = 1'b1;
    assign wbm.wbm_bte_o = 2'b00;
    assign wbm.wbm_cyc_o = active;
    assign wbm.wbm_stb_o = active;
    assign wbm.wbm_cti_o = !active  ? 3'b000 :
                           last_beat ? 3'b111 : 3'b010;

    // an errored beat never pops, even if ack arrives with it
    assign fifo_rd = wbm.wbm_ack_i & ~wbm.wbm_err_i & active;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            err       <= 1'b0;
            tx_cnt    <= '0;
            burst_cnt <= '0;
`ifdef WB_STREAM_READER_IRQ_EN
            irq       <= 1'b0;
`endif
        end else begin
`ifdef WB_STREAM_READER_IRQ_EN
            irq <= 1'b0;
`endif
            unique case (state)
                S_IDLE: begin
                    burst_cnt <= '0;
                    if (enable && !busy) begin
                        busy <= 1'b1;
                        err  <= 1'b0;
                    end
                    if (busy && fifo_ok)
                        state <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (wbm.wbm_err_i) begin
                        state <= S_IDLE;
                        err   <= 1'b1;
                        busy  <= 1'b0;
`ifdef WB_STREAM_READER_IRQ_EN
                        irq   <= 1'b1;
`endif
                    end else if (wbm.wbm_ack_i) begin
                        burst_cnt <= burst_cnt + WB_AW'(1);
                        tx_cnt    <= last_adr ? '0 : tx_cnt + WB_DW'(1);
                        if (last_beat) begin
                            state     <= S_IDLE;
                            burst_cnt <= '0;
                            if (last_adr) begin
                                busy <= 1'b0;
`ifdef WB_STREAM_READER_IRQ_EN
                                irq  <= 1'b1;
`endif
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stream_reader_ctrl.sv
// Scoreboard bench for wb_stream_reader_ctrl: expected beats are queued
// by the stimulus and popped by a monitor on every accepted Wishbone beat.
module tb_wb_stream_reader_ctrl;

    typedef struct {
        logic [31:0] adr;
        logic [2:0]  cti;
        logic [31:0] dat;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fifo_d = 32'hA000_0000;
    logic        fifo_rd;
    logic [4:0]  fifo_cnt = '0;
    logic        busy;
    logic        enable = 1'b0;
    logic [31:0] tx_cnt;
    logic [31:0] start_adr = '0;
    logic [31:0] buf_size = '0;
    logic [31:0] burst_size = 32'd4;
    logic        err;
`ifdef WB_STREAM_READER_IRQ_EN
    logic        irq;
`endif

    int    checks = 0;
    int    errors = 0;
    int    pops = 0;
    int    beat = 0;
    int    stall_beat = -1;
    int    stall_n = 0;
    int    stall_cyc = 0;
    int    err_beat = -1;
    int    irq_cnt = 0;
    logic  rd_seen = 1'b0;
    beat_t exp_q[$];

    wb_stream_reader_ctrl_if #(.WB_AW(32), .WB_DW(32)) ifc();

    wb_stream_reader_ctrl #(
        .WB_AW(32), .WB_DW(32), .FIFO_AW(4), .MAX_BURST_LEN(8)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbm       (ifc),
        .fifo_d    (fifo_d),
        .fifo_rd   (fifo_rd),
        .fifo_cnt  (fifo_cnt),
        .busy      (busy),
        .enable    (enable),
        .tx_cnt    (tx_cnt),
        .start_adr (start_adr),
        .buf_size  (buf_size),
        .burst_size(burst_size),
`ifdef WB_STREAM_READER_IRQ_EN
        .irq       (irq),
`endif
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Wishbone slave and FIFO head model, driven just after each edge
    initial begin
        ifc.wbm_ack_i = 1'b0;
        ifc.wbm_err_i = 1'b0;
        ifc.wbm_dat_i = '0;
        forever begin
            @(posedge clk);
            if (ifc.wbm_ack_i) beat++;
            if (rd_seen) begin
                fifo_d  = fifo_d + 32'd1;
                rd_seen = 1'b0;
            end
            #1;
            ifc.wbm_ack_i = 1'b0;
            ifc.wbm_err_i = 1'b0;
            if (ifc.wbm_cyc_o && ifc.wbm_stb_o) begin
                if (beat == err_beat)
                    ifc.wbm_err_i = 1'b1;
                else if (beat == stall_beat && stall_n > 0)
                    stall_n--;
                else
                    ifc.wbm_ack_i = 1'b1;
            end
        end
    end

    // monitor: compares every accepted beat against the scoreboard
    always @(negedge clk) begin
        beat_t e;
        if (fifo_rd) begin
            pops++;
            rd_seen = 1'b1;
        end
`ifdef WB_STREAM_READER_IRQ_EN
        if (irq) irq_cnt++;
`endif
        if (ifc.wbm_cyc_o && ifc.wbm_stb_o && !ifc.wbm_err_i) begin
            if (ifc.wbm_ack_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", ifc.wbm_adr_o, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_adr", ifc.wbm_adr_o, e.adr);
                    chk("beat_cti", 32'(ifc.wbm_cti_o), 32'(e.cti));
                    chk("beat_dat", ifc.wbm_dat_o, e.dat);
                    chk("beat_rd", 32'(fifo_rd), 32'd1);
                end
            end else begin
                stall_cyc++;
                chk("stall_rd", 32'(fifo_rd), 32'd0);
                if (exp_q.size() != 0) begin
                    chk("stall_adr", ifc.wbm_adr_o, exp_q[0].adr);
                    chk("stall_cti", 32'(ifc.wbm_cti_o), 32'(exp_q[0].cti));
                    chk("stall_dat", ifc.wbm_dat_o, exp_q[0].dat);
                end
            end
        end
    end

    task automatic push_beats(logic [31:0] base, int tx0, int n, int bs);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.adr = base + 32'(4 * (tx0 + i));
            b.cti = ((i % bs) == bs - 1) ? 3'b111 : 3'b010;
            b.dat = fifo_d + 32'(i);
            exp_q.push_back(b);
        end
    endtask

    task automatic pulse_enable();
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_beat(int k);
        int n = 0;
        while (beat < k && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("beat_timeout", 32'(beat >= k), 32'd1);
    endtask

    initial begin
        #2;
        chk("rst_cyc", 32'(ifc.wbm_cyc_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_tx", tx_cnt, 32'd0);
        chk("rst_cti", 32'(ifc.wbm_cti_o), 32'd0);
        chk("rst_we", 32'(ifc.wbm_we_o), 32'd1);
        chk("rst_sel", 32'(ifc.wbm_sel_o), 32'hF);
        chk("rst_bte", 32'(ifc.wbm_bte_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // two full bursts over a 32-byte buffer
        start_adr = 32'h1000; buf_size = 32; burst_size = 4;
        fifo_cnt = 8; pops = 0; beat = 0; irq_cnt = 0;
        push_beats(32'h1000, 0, 8, 4);
        pulse_enable();
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_cyc_early", 32'(ifc.wbm_cyc_o), 32'd0);
        @(negedge clk);
        chk("t1_latency", 32'(ifc.wbm_cyc_o), 32'd1);
        wait_idle("t1");
`ifdef WB_STREAM_READER_IRQ_EN
        chk("t1_irq_at_fall", 32'(irq), 32'd1);
`endif
        chk("t1_tx", tx_cnt, 32'd0);
        @(negedge clk);
        chk("t1_pops", 32'(pops), 32'd8);
        chk("t1_q", 32'(exp_q.size()), 32'd0);
`ifdef WB_STREAM_READER_IRQ_EN
        chk("t1_irq_cnt", 32'(irq_cnt), 32'd1);
`endif

        // waits for a full burst in the FIFO
        start_adr = 32'h2000; buf_size = 16; fifo_cnt = 3;
        pops = 0; beat = 0;
        pulse_enable();
        repeat (4) @(negedge clk);
        chk("t2_cyc_wait", 32'(ifc.wbm_cyc_o), 32'd0);
        chk("t2_busy", 32'(busy), 32'd1);
        push_beats(32'h2000, 0, 4, 4);
        fifo_cnt = 4;
        @(negedge clk);
        chk("t2_cyc_go", 32'(ifc.wbm_cyc_o), 32'd1);
        wait_idle("t2");
        chk("t2_tx", tx_cnt, 32'd0);
        @(negedge clk);
        chk("t2_pops", 32'(pops), 32'd4);
        chk("t2_q", 32'(exp_q.size()), 32'd0);

        // three wait states on the first beat
        start_adr = 32'h3000; fifo_cnt = 8;
        pops = 0; beat = 0; stall_cyc = 0;
        stall_beat = 0; stall_n = 3;
        push_beats(32'h3000, 0, 4, 4);
        pulse_enable();
        wait_idle("t3");
        stall_beat = -1;
        @(negedge clk);
        chk("t3_stall_cyc", 32'(stall_cyc), 32'd3);
        chk("t3_pops", 32'(pops), 32'd4);
        chk("t3_tx", tx_cnt, 32'd0);

        // bus error on the second beat
        start_adr = 32'h4000; pops = 0; beat = 0; err_beat = 1;
        push_beats(32'h4000, 0, 1, 4);
        pulse_enable();
        wait_idle("t4");
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_cyc", 32'(ifc.wbm_cyc_o), 32'd0);
        chk("t4_tx", tx_cnt, 32'd1);
        err_beat = -1;
        @(negedge clk);
        chk("t4_pops", 32'(pops), 32'd1);
        chk("t4_q", 32'(exp_q.size()), 32'd0);

        // next enable clears the sticky error
        fifo_cnt = 0;
        pulse_enable();
        chk("t4_err_clr", 32'(err), 32'd0);
        chk("t4_busy_again", 32'(busy), 32'd1);

        // asynchronous reset in the middle of a stalled burst
        pops = 0; beat = 0;
        stall_beat = 2; stall_n = 50;
        push_beats(32'h4000, 1, 2, 4);
        fifo_cnt = 8;
        wait_beat(2);
        repeat (2) @(negedge clk);
        chk("t5_cyc_pre", 32'(ifc.wbm_cyc_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_cyc", 32'(ifc.wbm_cyc_o), 32'd0);
        chk("t5_stb", 32'(ifc.wbm_stb_o), 32'd0);
        chk("t5_rd", 32'(fifo_rd), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_tx", tx_cnt, 32'd0);
        stall_n = 0; stall_beat = -1;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_pops", 32'(pops), 32'd2);
        chk("t5_q", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        chk("t5_idle_cyc", 32'(ifc.wbm_cyc_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
